// File: rtl/seq_pkg.sv
// Shared types and constants for the Simon sequence reader.
package seq_pkg;

    localparam int unsigned MAX_LEVEL = 16;
    localparam int unsigned STEP_W    = 2;
    localparam int unsigned SEED_W    = 32;
    localparam int unsigned IDX_W     = 4;
    localparam int unsigned LEVEL_W   = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHOW_ON,
        ST_SHOW_OFF,
        ST_WAIT_IN,
        ST_FAIL,
        ST_WIN
    } seq_state_t;

    typedef enum logic [STEP_W-1:0] {
        GREEN  = 2'd0,
        RED    = 2'd1,
        YELLOW = 2'd2,
        BLUE   = 2'd3
    } colour_t;

    // Step i of the sequence is the 2-bit field at bit 2i of the seed.
    function automatic colour_t step_colour(input logic [SEED_W-1:0] s, input logic [IDX_W-1:0] i);
        return colour_t'(s[{i, 1'b0} +: STEP_W]);
    endfunction

endpackage

// File: rtl/seq_reader_if.sv
// Game-side bus of the sequence reader: seed/control in, LED and status out.
interface seq_reader_if;
    import seq_pkg::*;

    logic [SEED_W-1:0]  seed;
    logic               load_seed;
    logic               start_show;
    logic               btn_valid;
    logic [STEP_W-1:0]  btn_colour;
    logic               led_on;
    logic [STEP_W-1:0]  led_colour;
    logic               show_busy;
    logic               expect_input;
    logic               step_ok;
    logic               round_done;
    logic               fail;
    logic               win;
    logic [LEVEL_W-1:0] level;

    modport master (
        output seed, load_seed, start_show, btn_valid, btn_colour,
        input  led_on, led_colour, show_busy, expect_input,
               step_ok, round_done, fail, win, level
    );

    modport slave (
        input  seed, load_seed, start_show, btn_valid, btn_colour,
        output led_on, led_colour, show_busy, expect_input,
               step_ok, round_done, fail, win, level
    );

endinterface

// File: rtl/seq_reader_step_timer.sv
// Step timer: up-counter with synchronous clear and terminal-count flag.
module step_timer #(
    parameter int unsigned CNT_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [CNT_W-1:0] limit,
    output logic             done
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)      count_q <= '0;
        else if (clear) count_q <= '0;
        else            count_q <= count_q + CNT_W'(1);
    end

    assign done = (count_q == limit);

endmodule

// File: rtl/seq_reader.sv
// Simon sequence reader: latches the seed, plays the current level on the LEDs
// and checks the player's presses against the same steps.
module seq_reader
    import seq_pkg::*;
#(
    parameter int unsigned ON_CYCLES  = 12_500_000,
    parameter int unsigned OFF_CYCLES = 6_250_000,
    parameter int unsigned CNT_W      = 24
) (
    input  logic         clk,
    input  logic         reset,
    seq_reader_if.slave  bus
);

    seq_state_t          state_q, state_n;
    logic [SEED_W-1:0]   seed_q, seed_n;
    logic [IDX_W-1:0]    idx_q, idx_n;
    logic [LEVEL_W-1:0]  level_q, level_n;
    logic                step_ok_n, round_done_n, fail_n;
    logic                timer_clear_c, timer_done_c;
    logic [CNT_W-1:0]    timer_limit_c;
    logic [IDX_W-1:0]    last_idx_c;
    logic [STEP_W-1:0]   cur_colour_c;

    logic                led_on_q, show_busy_q, expect_input_q;
    logic                step_ok_q, round_done_q, fail_q, win_q;
    logic [STEP_W-1:0]   led_colour_q;

    assign last_idx_c    = IDX_W'(level_q - LEVEL_W'(1));
    assign cur_colour_c  = STEP_W'(step_colour(seed_q, idx_q));
    assign timer_limit_c = (state_q == ST_SHOW_ON) ? CNT_W'(ON_CYCLES - 1) : CNT_W'(OFF_CYCLES - 1);

    step_timer #(.CNT_W(CNT_W)) u_timer (
        .clk   (clk),
        .reset (reset),
        .clear (timer_clear_c),
        .limit (timer_limit_c),
        .done  (timer_done_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            seed_q  <= '0;
            idx_q   <= '0;
            level_q <= LEVEL_W'(1);
        end else begin
            state_q <= state_n;
            seed_q  <= seed_n;
            idx_q   <= idx_n;
            level_q <= level_n;
        end
    end

    // Next state; load_seed overrides everything and suppresses all pulses.
    always_comb begin
        state_n       = state_q;
        seed_n        = seed_q;
        idx_n         = idx_q;
        level_n       = level_q;
        step_ok_n     = 1'b0;
        round_done_n  = 1'b0;
        fail_n        = 1'b0;
        timer_clear_c = !(state_q inside {ST_SHOW_ON, ST_SHOW_OFF}) || timer_done_c;

        if (bus.load_seed) begin
            seed_n        = bus.seed;
            level_n       = LEVEL_W'(1);
            idx_n         = '0;
            state_n       = ST_IDLE;
            timer_clear_c = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start_show) begin
                        idx_n   = '0;
                        state_n = ST_SHOW_ON;
                    end
                end
                ST_SHOW_ON: begin
                    if (timer_done_c) state_n = ST_SHOW_OFF;
                end
                ST_SHOW_OFF: begin
                    if (timer_done_c) begin
                        if (idx_q == last_idx_c) begin
                            idx_n   = '0;
                            state_n = ST_WAIT_IN;
                        end else begin
                            idx_n   = idx_q + IDX_W'(1);
                            state_n = ST_SHOW_ON;
                        end
                    end
                end
                ST_WAIT_IN: begin
                    if (bus.btn_valid) begin
                        if (bus.btn_colour == cur_colour_c) begin
                            step_ok_n = 1'b1;
                            if (idx_q == last_idx_c) begin
                                round_done_n = 1'b1;
                                idx_n        = '0;
                                if (level_q == LEVEL_W'(MAX_LEVEL)) begin
                                    state_n = ST_WIN;
                                end else begin
                                    level_n = level_q + LEVEL_W'(1);
                                    state_n = ST_IDLE;
                                end
                            end else begin
                                idx_n = idx_q + IDX_W'(1);
                            end
                        end else begin
                            fail_n  = 1'b1;
                            state_n = ST_FAIL;
                        end
                    end
                end
                ST_FAIL, ST_WIN: state_n = state_q;
                default:         state_n = ST_IDLE;
            endcase
        end
    end

    // Outputs follow the next state so they line up with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_on_q       <= 1'b0;
            led_colour_q   <= '0;
            show_busy_q    <= 1'b0;
            expect_input_q <= 1'b0;
            step_ok_q      <= 1'b0;
            round_done_q   <= 1'b0;
            fail_q         <= 1'b0;
            win_q          <= 1'b0;
        end else begin
            led_on_q       <= (state_n == ST_SHOW_ON);
            led_colour_q   <= (state_n == ST_SHOW_ON) ? STEP_W'(step_colour(seed_n, idx_n)) : '0;
            show_busy_q    <= (state_n inside {ST_SHOW_ON, ST_SHOW_OFF});
            expect_input_q <= (state_n == ST_WAIT_IN);
            step_ok_q      <= step_ok_n;
            round_done_q   <= round_done_n;
            fail_q         <= fail_n;
            win_q          <= (state_n == ST_WIN);
        end
    end

    assign bus.led_on       = led_on_q;
    assign bus.led_colour   = led_colour_q;
    assign bus.show_busy    = show_busy_q;
    assign bus.expect_input = expect_input_q;
    assign bus.step_ok      = step_ok_q;
    assign bus.round_done   = round_done_q;
    assign bus.fail         = fail_q;
    assign bus.win          = win_q;
    assign bus.level        = level_q;

endmodule
